xgemac_rx_pkt_reader: RTL

Downstream consumer of the XGEMAC receive packet interface. Pulls frames from the MAC RX FIFO via pkt_rx_ren/pkt_rx_avail, checks SOP/EOP framing, and re-presents beats on a valid/ready stream through a small skid buffer. Keeps saturating per-frame and per-byte statistics for the RX monitor and scoreboard to cross-check.

---
 rtl/xgemac_package.sv | 34 +++
 rtl/xgemac_rx_skid_fifo.sv | 67 ++++++
 rtl/xgemac_rx_pkt_reader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/xgemac_package.sv
// Shared types and helpers for the XGEMAC receive packet reader.
// Contents:
//   XGEMAC_DATA_W / XGEMAC_MOD_W  MAC beat data width and byte-modulo width.
//   rx_rd_state_t                 reader framing state (IDLE, IN_FRAME).
//   rx_beat_t                     one buffered beat (data, sop, eop, mod, err).
//   bytes_of()                    byte count carried by a beat.
package xgemac_package;

    localparam int XGEMAC_DATA_W = 64;
    localparam int XGEMAC_MOD_W  = 3;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } rx_rd_state_t;

    typedef struct packed {
        logic [XGEMAC_DATA_W-1:0] data;
        logic                     sop;
        logic                     eop;
        logic [XGEMAC_MOD_W-1:0]  mod;
        logic                     err;
    } rx_beat_t;

    // A full beat carries 8 bytes; on EOP a zero modulo also means 8.
    function automatic logic [3:0] bytes_of(input logic eop,
                                            input logic [XGEMAC_MOD_W-1:0] mod);
        if (eop && (mod != '0)) begin
            return {1'b0, mod};
        end
        return 4'd8;
    endfunction

endpackage

// File: rtl/xgemac_rx_skid_fifo.sv
// Small synchronous FIFO of rx_beat_t that decouples MAC reads from the
// downstream valid/ready stream.
// Ports:
//   clk_i, rst_n_i   clock and synchronous active-low reset
//   push_i, wdata_i  write a beat (accepted when not full, or when full and popping)
//   pop_i, rdata_o   read side; rdata_o shows the head entry
//   count_o          current occupancy (0..DEPTH)
//   full_o, empty_o  occupancy flags
module xgemac_rx_skid_fifo
    import xgemac_package::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       push_i,
    input  rx_beat_t                   wdata_i,
    input  logic                       pop_i,
    output rx_beat_t                   rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    rx_beat_t        mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    // When full, a simultaneous pop frees the slot the push lands in.
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only observed behind count_q.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/xgemac_rx_pkt_reader.sv
// XGEMAC receive packet reader: pulls beats from the MAC RX FIFO, checks
// SOP/EOP framing, forwards accepted beats through a skid FIFO onto a
// valid/ready stream and keeps saturating frame/byte statistics.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | between frames; only an SOP beat is accepted
//   IN_FRAME | SOP seen, EOP not yet; keep reading even if avail drops
//
// Ports:
//   clk_156m25, reset_156m25_n     MAC clock, synchronous active-low reset
//   pkt_rx_avail / pkt_rx_ren      MAC has a frame / registered read enable
//   pkt_rx_val, _data, _sop, _eop,
//   _mod, _err                     beat returned one cycle after ren
//   out_valid/out_ready, out_*     forwarded beat stream
//   stat_clr, stat_*               statistics clear and counters
module xgemac_rx_pkt_reader
    import xgemac_package::*;
#(
    parameter int DATA_W    = 64,
    parameter int MOD_W     = 3,
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W     = 32
) (
    input  logic              clk_156m25,
    input  logic              reset_156m25_n,
    input  logic              pkt_rx_avail,
    output logic              pkt_rx_ren,
    input  logic              pkt_rx_val,
    input  logic [DATA_W-1:0] pkt_rx_data,
    input  logic              pkt_rx_sop,
    input  logic              pkt_rx_eop,
    input  logic [MOD_W-1:0]  pkt_rx_mod,
    input  logic              pkt_rx_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic [MOD_W-1:0]  out_mod,
    output logic              out_err,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stat_good_frames,
    output logic [CNT_W-1:0]  stat_err_frames,
    output logic [CNT_W-1:0]  stat_bytes,
    output logic [CNT_W-1:0]  stat_frame_viol
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    rx_rd_state_t     state_q;
    logic             ren_q;
    logic [CNT_W-1:0] good_q;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] bytes_q;
    logic [CNT_W-1:0] viol_q;

    logic             in_frame;
    logic             beat_accept;
    logic             sop_in_frame;
    logic             stray_beat;
    logic             eop_beat;
    logic             good_inc;
    logic [1:0]       err_inc;
    logic [3:0]       bytes_inc;
    logic             room;
    logic             ren_d;

    rx_beat_t         push_beat;
    rx_beat_t         head_beat;
    rx_beat_t         out_beat;
    logic             fifo_push;
    logic             fifo_pop;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cur,
                                                 input logic [3:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cur} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    assign in_frame     = (state_q == IN_FRAME);
    assign beat_accept  = pkt_rx_val & (pkt_rx_sop | in_frame);
    assign sop_in_frame = pkt_rx_val & pkt_rx_sop & in_frame;
    assign stray_beat   = pkt_rx_val & ~pkt_rx_sop & ~in_frame;
    assign eop_beat     = beat_accept & pkt_rx_eop;
    assign good_inc     = eop_beat & ~pkt_rx_err;
    // An SOP inside a frame closes the previous frame bad; if that same beat
    // is also an errored EOP, both frames count.
    assign err_inc      = {1'b0, sop_in_frame} + {1'b0, eop_beat & pkt_rx_err};
    assign bytes_inc    = beat_accept ? bytes_of(pkt_rx_eop, pkt_rx_mod) : 4'd0;

    // Need two free slots: the beat answering the current ren and the one
    // answering the ren being decided now.
    assign room  = ({1'b0, fifo_count} + (CW+1)'(ren_q) + (CW+1)'(2)) <= (CW+1)'(BUF_DEPTH);
    assign ren_d = (pkt_rx_avail | in_frame) & room;

    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            state_q <= IDLE;
            ren_q   <= 1'b0;
            good_q  <= '0;
            err_q   <= '0;
            bytes_q <= '0;
            viol_q  <= '0;
        end else begin
            ren_q <= ren_d;
            if (beat_accept) begin
                state_q <= pkt_rx_eop ? IDLE : IN_FRAME;
            end
            if (stat_clr) begin
                good_q  <= '0;
                err_q   <= '0;
                bytes_q <= '0;
                viol_q  <= '0;
            end else begin
                good_q  <= sat_add(good_q, {3'b000, good_inc});
                err_q   <= sat_add(err_q, {2'b00, err_inc});
                bytes_q <= sat_add(bytes_q, bytes_inc);
                viol_q  <= sat_add(viol_q, {3'b000, sop_in_frame | stray_beat});
            end
        end
    end

    assign push_beat = '{data: pkt_rx_data,
                         sop:  pkt_rx_sop,
                         eop:  pkt_rx_eop,
                         mod:  pkt_rx_mod,
                         err:  pkt_rx_eop & pkt_rx_err};
    assign fifo_push = beat_accept;
    assign fifo_pop  = out_valid & out_ready;

    xgemac_rx_skid_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_skid_fifo (
        .clk_i   (clk_156m25),
        .rst_n_i (reset_156m25_n),
        .push_i  (fifo_push),
        .wdata_i (push_beat),
        .pop_i   (fifo_pop),
        .rdata_o (head_beat),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Stale storage is never visible: outputs are zero while the buffer is empty.
    assign out_beat  = fifo_empty ? '0 : head_beat;
    assign out_valid = ~fifo_empty;
    assign out_data  = out_beat.data;
    assign out_sop   = out_beat.sop;
    assign out_eop   = out_beat.eop;
    assign out_mod   = out_beat.mod;
    assign out_err   = out_beat.err;

    assign pkt_rx_ren       = ren_q;
    assign stat_good_frames = good_q;
    assign stat_err_frames  = err_q;
    assign stat_bytes       = bytes_q;
    assign stat_frame_viol  = viol_q;

    a_no_overflow: assert property (@(posedge clk_156m25) disable iff (!reset_156m25_n)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule
